multicycle_ctrl: RTL

Multi-cycle main control unit: the producing end of the ALUOp interface that the ALU controller decodes. It sequences each MIPS-subset instruction through fetch, decode, execute, memory and write-back states. Per state, it drives datapath strobes, mux selects and the 3-bit ALUOp. It sits between the instruction register and memory handshake on one side, and the shared-ALU multi-cycle datapath on the other.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl_outdec.sv | 91 +++++++++
 rtl/multicycle_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode-class, opcode/funct and ALUOp encodings shared by the main control and the ALU controller.
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
        S_WB_R = 4'd4, S_WB_I = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8, S_WB_MEM = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
        S_JR = 4'd12, S_TRAP = 4'd15
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_JR, C_ADDI, C_SLTI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } cls_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b100;
    localparam logic [2:0] ALUOP_ADDR  = 3'b111;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    function automatic cls_e decode_cls(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return fn == FN_JR ? C_JR :
                             fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT} ? C_R : C_ILL;
            OP_ADDI:  return C_ADDI;
            OP_SLTI:  return C_SLTI;
            OP_BEQ:   return C_BEQ;
            OP_LW:    return C_LW;
            OP_SW:    return C_SW;
            OP_J:     return C_J;
            OP_JAL:   return C_JAL;
            default:  return C_ILL;
        endcase
    endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/memory inputs and datapath control outputs of the main control unit.
interface multicycle_ctrl_if;
    logic [5:0] instr_op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       ir_write_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       i_or_d_o;
    logic       reg_write_o;
    logic [1:0] reg_dst_o;
    logic [1:0] mem_to_reg_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic [1:0] pc_src_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic [3:0] state_o;

    modport master (
        input  instr_op_i, funct_i, zero_i, mem_ready_i,
        output pc_write_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o, reg_write_o,
               reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
               instr_done_o, illegal_o, state_o
    );
    modport slave (
        output instr_op_i, funct_i, zero_i, mem_ready_i,
        input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o, reg_write_o,
               reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
               instr_done_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// multicycle_ctrl_outdec: per-state datapath controls; Mealy only on mem_ready_i (FETCH, MEM_WR done) and zero_i (BRANCH).
module multicycle_ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_e state_i,
    input  cls_e   cls_i,
    input  logic   rst_i,
    input  logic   mem_ready_i,
    input  logic   zero_i,
    output ctrl_t  ctrl_o
);
    ctrl_t c;

    always_comb begin
        c = '0;
        case (state_i)
            S_FETCH: begin
                c.pc_write  = mem_ready_i;
                c.ir_write  = mem_ready_i;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = cls_i == C_SLTI ? ALUOP_SLT : ALUOP_ADD;
            end
            S_WB_R: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b01;
                c.instr_done = 1'b1;
            end
            S_WB_I: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALUOP_ADDR;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = mem_ready_i;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = ALUOP_SUB;
                c.pc_src     = 2'b01;
                c.pc_write   = zero_i;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_src     = 2'b10;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
                c.reg_write  = cls_i == C_JAL;
                c.reg_dst    = cls_i == C_JAL ? 2'b10 : 2'b00;
                c.mem_to_reg = cls_i == C_JAL ? 2'b10 : 2'b00;
            end
            S_JR: begin
                c.pc_src     = 2'b11;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset blanks everything so an aborted instruction leaves no trace on the datapath.
    assign ctrl_o = rst_i ? '0 : c;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS-subset main control FSM (state and opcode-class registers, next-state logic).
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input logic             clk_i,
    input logic             rst_i,
    multicycle_ctrl_if.master bus
);
    state_e state_q, state_d;
    cls_e   cls_q, cls_d, cls_dec;
    logic   illegal_q;
    ctrl_t  ctrl;

    assign cls_dec = decode_cls(bus.instr_op_i, bus.funct_i);
    assign cls_d   = state_q == S_DECODE ? cls_dec : cls_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:
                case (cls_dec)
                    C_R:            state_d = S_EXEC_R;
                    C_JR:           state_d = S_JR;
                    C_ADDI, C_SLTI: state_d = S_EXEC_I;
                    C_LW, C_SW:     state_d = S_MEM_ADDR;
                    C_BEQ:          state_d = S_BRANCH;
                    C_J, C_JAL:     state_d = S_JUMP;
                    default:        state_d = S_TRAP;
                endcase
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = cls_q == C_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = bus.mem_ready_i ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = bus.mem_ready_i ? S_FETCH : S_MEM_WR;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .cls_i       (cls_q),
        .rst_i       (rst_i),
        .mem_ready_i (bus.mem_ready_i),
        .zero_i      (bus.zero_i),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write_o   = ctrl.pc_write;
    assign bus.ir_write_o   = ctrl.ir_write;
    assign bus.mem_read_o   = ctrl.mem_read;
    assign bus.mem_write_o  = ctrl.mem_write;
    assign bus.i_or_d_o     = ctrl.i_or_d;
    assign bus.reg_write_o  = ctrl.reg_write;
    assign bus.reg_dst_o    = ctrl.reg_dst;
    assign bus.mem_to_reg_o = ctrl.mem_to_reg;
    assign bus.alu_src_a_o  = ctrl.alu_src_a;
    assign bus.alu_src_b_o  = ctrl.alu_src_b;
    assign bus.alu_op_o     = ctrl.alu_op;
    assign bus.pc_src_o     = ctrl.pc_src;
    assign bus.instr_done_o = ctrl.instr_done;
    assign bus.illegal_o    = illegal_q;
    assign bus.state_o      = state_q;
endmodule
